// File: rtl/pe_row_output_collector.sv
// Drains one PE row's shifted outputs, packs them into memory words and writes them to output SRAM.
// Optional define COLLECTOR_BYTE_MASK_EN adds a wr_be byte-enable output that masks zero-filled lanes.
//
// state   | meaning
// IDLE    | waiting for start; configuration latched on start
// COLLECT | accepting values from the PE chain, packing lanes
// FLUSH   | last value taken; waiting for the final write grant
// WAIT_WR | not entered; buffer stalls are absorbed in COLLECT via in_ready
// DONE    | one-cycle done pulse
module pe_row_output_collector #(
  parameter int ACC_DATA_WIDTH = 32,
  parameter int ACT_DATA_WIDTH = 8,
  parameter int N_PE           = 16,
  parameter int MEM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH     = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      raw_mode,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [7:0]                num_rows,
  input  logic [ACC_DATA_WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      wr_req,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [MEM_DATA_WIDTH-1:0] wr_data,
`ifdef COLLECTOR_BYTE_MASK_EN
  output logic [MEM_DATA_WIDTH/8-1:0] wr_be,
`endif
  input  logic                      wr_gnt,
  output logic                      busy,
  output logic                      done
);

  localparam int LA = MEM_DATA_WIDTH / ACT_DATA_WIDTH;
  localparam int LR = MEM_DATA_WIDTH / ACC_DATA_WIDTH;
  localparam int LW = (LA > 1) ? $clog2(LA) : 1;
  localparam int PW = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int NB = MEM_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, COLLECT, FLUSH, WAIT_WR, DONE} state_t;

  state_t                    state_q, state_d;
  logic                      raw_q, raw_d;
  logic [7:0]                rows_q, rows_d;
  logic [7:0]                row_q, row_d;
  logic [LW-1:0]             lane_q, lane_d;
  logic [PW-1:0]             pe_q, pe_d;
  logic [MEM_DATA_WIDTH-1:0] acc_q, acc_d;
  logic                      buf_valid_q, buf_valid_d;
  logic [MEM_DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [MEM_DATA_WIDTH-1:0] word;
  logic                      xfer, gnt, lane_last, pe_last, row_last;
`ifdef COLLECTOR_BYTE_MASK_EN
  logic [NB-1:0]             be_q, be_d, word_be;
`endif

  // The buffer may be refilled in the cycle it is granted, so ready looks through wr_gnt.
  assign in_ready  = (state_q == COLLECT) && (!buf_valid_q || wr_gnt);
  assign xfer      = in_valid && in_ready;
  assign gnt       = wr_gnt && buf_valid_q;
  assign lane_last = raw_q ? (lane_q == LW'(LR - 1)) : (lane_q == LW'(LA - 1));
  assign pe_last   = (pe_q == PW'(N_PE - 1));
  assign row_last  = (row_q == rows_q - 8'd1);

  assign wr_req  = buf_valid_q;
  assign wr_addr = addr_q;
  assign wr_data = buf_data_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
`ifdef COLLECTOR_BYTE_MASK_EN
  assign wr_be   = be_q;
`endif

  always_comb begin
    state_d     = state_q;
    raw_d       = raw_q;
    rows_d      = rows_q;
    row_d       = row_q;
    lane_d      = lane_q;
    pe_d        = pe_q;
    acc_d       = acc_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    addr_d      = addr_q;
    word        = acc_q;
    for (int k = 0; k < LA; k++)
      if (!raw_q && lane_q == LW'(k)) word[k*ACT_DATA_WIDTH +: ACT_DATA_WIDTH] = in_data[ACT_DATA_WIDTH-1:0];
    for (int k = 0; k < LR; k++)
      if (raw_q && lane_q == LW'(k)) word[k*ACC_DATA_WIDTH +: ACC_DATA_WIDTH] = in_data;
`ifdef COLLECTOR_BYTE_MASK_EN
    be_d    = be_q;
    word_be = '0;
    for (int b = 0; b < NB; b++)
      word_be[b] = raw_q ? (LW'(b / (ACC_DATA_WIDTH / 8)) <= lane_q)
                         : (LW'(b / (ACT_DATA_WIDTH / 8)) <= lane_q);
`endif

    if (gnt) begin
      buf_valid_d = 1'b0;
      addr_d      = addr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          raw_d   = raw_mode;
          rows_d  = (num_rows == 8'd0) ? 8'd1 : num_rows;
          addr_d  = base_addr;
          row_d   = '0;
          lane_d  = '0;
          pe_d    = '0;
          acc_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (xfer) begin
          if (lane_last || pe_last) begin
            buf_valid_d = 1'b1;
            buf_data_d  = word;
`ifdef COLLECTOR_BYTE_MASK_EN
            be_d        = word_be;
`endif
            acc_d       = '0;
            lane_d      = '0;
          end else begin
            acc_d  = word;
            lane_d = lane_q + 1'b1;
          end
          if (pe_last) begin
            pe_d  = '0;
            row_d = row_q + 8'd1;
            if (row_last) state_d = FLUSH;
          end else begin
            pe_d = pe_q + 1'b1;
          end
        end
      end
      FLUSH:   if (!buf_valid_q || wr_gnt) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      raw_q       <= 1'b0;
      rows_q      <= '0;
      row_q       <= '0;
      lane_q      <= '0;
      pe_q        <= '0;
      acc_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      addr_q      <= '0;
`ifdef COLLECTOR_BYTE_MASK_EN
      be_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      raw_q       <= raw_d;
      rows_q      <= rows_d;
      row_q       <= row_d;
      lane_q      <= lane_d;
      pe_q        <= pe_d;
      acc_q       <= acc_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      addr_q      <= addr_d;
`ifdef COLLECTOR_BYTE_MASK_EN
      be_q        <= be_d;
`endif
    end
  end

endmodule

// File: tb/tb_pe_row_output_collector.sv
// Directed bench for pe_row_output_collector: scoreboard of expected writes, checked on every granted write.
// A second instance with N_PE=5 covers the partial-word row end (and wr_be under COLLECTOR_BYTE_MASK_EN).
module tb_pe_row_output_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, raw_mode, in_valid, in_ready, wr_req, wr_gnt, busy, done;
  logic [11:0] base_addr, wr_addr;
  logic [7:0]  num_rows;
  logic [31:0] in_data;
  logic [63:0] wr_data;

  logic        start5, in_valid5, in_ready5, wr_req5, wr_gnt5, busy5, done5;
  logic [11:0] wr_addr5;
  logic [31:0] in_data5;
  logic [63:0] wr_data5;
`ifdef COLLECTOR_BYTE_MASK_EN
  logic [7:0]  wr_be, wr_be5;
`endif

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;
  logic [75:0] q[$];
  logic [75:0] q5[$];

  always #5 clk = ~clk;

  pe_row_output_collector dut (
    .clk(clk), .reset(reset), .start(start), .raw_mode(raw_mode), .base_addr(base_addr),
    .num_rows(num_rows), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef COLLECTOR_BYTE_MASK_EN
    .wr_be(wr_be),
`endif
    .wr_gnt(wr_gnt), .busy(busy), .done(done)
  );

  pe_row_output_collector #(.N_PE(5)) dut5 (
    .clk(clk), .reset(reset), .start(start5), .raw_mode(1'b0), .base_addr(12'h0AB),
    .num_rows(8'd1), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .wr_req(wr_req5), .wr_addr(wr_addr5), .wr_data(wr_data5),
`ifdef COLLECTOR_BYTE_MASK_EN
    .wr_be(wr_be5),
`endif
    .wr_gnt(wr_gnt5), .busy(busy5), .done(done5)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_req && wr_gnt) begin
      if (q.size() == 0) begin
        total++;
        $error("FAIL unexpected_write observed addr=%0h data=%0h expected no write", wr_addr, wr_data);
      end else begin
        logic [75:0] e;
        e = q.pop_front();
        check("wr_addr", {52'd0, wr_addr}, {52'd0, e[75:64]});
        check("wr_data", wr_data, e[63:0]);
      end
    end
    if (wr_req5 && wr_gnt5) begin
      if (q5.size() == 0) begin
        total++;
        $error("FAIL unexpected_write5 observed addr=%0h data=%0h expected no write", wr_addr5, wr_data5);
      end else begin
        logic [75:0] e;
        e = q5.pop_front();
        check("p5_addr", {52'd0, wr_addr5}, {52'd0, e[75:64]});
        check("p5_data", wr_data5, e[63:0]);
`ifdef COLLECTOR_BYTE_MASK_EN
        check("p5_be", {56'd0, wr_be5}, 64'h1F);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_drain(input logic r, input logic [11:0] b, input logic [7:0] n);
    raw_mode  = r;
    base_addr = b;
    num_rows  = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        total++;
        $error("FAIL send_timeout observed in_ready=0 expected 1 within 200 cycles");
        break;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    int d0;
    d0 = done_cnt;
    while (n < 400) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
    #1;
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_sb_empty"}, 64'(q.size()), 64'd0);
  endtask

  task automatic push_case1(input logic [11:0] b);
    q.push_back({b, 64'h0706050403020100});
    q.push_back({b + 12'd1, 64'h0F0E0D0C0B0A0908});
  endtask

  initial begin
    logic [11:0] a0;
    logic [63:0] d0;
    logic [63:0] w;
    int dc;
    reset = 1'b0; start = 1'b0; raw_mode = 1'b0; base_addr = '0; num_rows = '0;
    in_data = '0; in_valid = 1'b0; wr_gnt = 1'b1;
    start5 = 1'b0; in_valid5 = 1'b0; in_data5 = '0; wr_gnt5 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_req", {63'd0, wr_req}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_wr_addr", {52'd0, wr_addr}, 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
    reset = 1'b1;
    tick();

    // Case 1: activation mode; junk offered while idle and a second start mid-drain must both be ignored
    in_valid = 1'b1; in_data = 32'hEE;
    tick(); tick();
    in_valid = 1'b0;
    start_drain(1'b0, 12'h040, 8'd1);
    push_case1(12'h040);
    start = 1'b1; base_addr = 12'h300; raw_mode = 1'b1;
    send(32'd0);
    start = 1'b0;
    check("c1_busy", {63'd0, busy}, 64'd1);
    for (int i = 1; i < 16; i++) send(32'(i));
    wait_done("c1");

    // Raw mode with num_rows=0 (one row)
    start_drain(1'b1, 12'h100, 8'd0);
    for (int j = 0; j < 8; j++)
      q.push_back({12'(12'h100 + j), 32'(32'h101 + 2 * j), 32'(32'h100 + 2 * j)});
    for (int i = 0; i < 16; i++) send(32'(32'h100 + i));
    wait_done("raw");

    // Two rows, activation mode
    start_drain(1'b0, 12'h200, 8'd2);
    for (int k = 0; k < 4; k++) begin
      w = '0;
      for (int b = 0; b < 8; b++) w[8*b +: 8] = 8'(8 * k + b);
      q.push_back({12'(12'h200 + k), w});
    end
    for (int i = 0; i < 32; i++) send(32'(i));
    wait_done("rows2");

    // Backpressure: grant withheld for 20 cycles after the first word
    wr_gnt = 1'b0;
    start_drain(1'b0, 12'h080, 8'd1);
    push_case1(12'h080);
    for (int i = 0; i < 7; i++) send(32'(i));
    check("bp_no_req_yet", {63'd0, wr_req}, 64'd0);
    send(32'd7);
    in_valid = 1'b1; in_data = 32'd8;
    @(negedge clk);
    check("bp_req_latency", {63'd0, wr_req}, 64'd1);
    check("bp_ready_low", {63'd0, in_ready}, 64'd0);
    a0 = wr_addr;
    d0 = wr_data;
    check("bp_addr0", {52'd0, a0}, 64'h080);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_addr_stable", {52'd0, wr_addr}, {52'd0, a0});
      check("bp_data_stable", wr_data, d0);
      check("bp_ready_stall", {63'd0, in_ready}, 64'd0);
    end
    tick();
    wr_gnt = 1'b1;
    for (int i = 8; i < 16; i++) send(32'(i));
    wait_done("bp");

    // Address wrap
    start_drain(1'b0, 12'hFFF, 8'd1);
    q.push_back({12'hFFF, 64'h0706050403020100});
    q.push_back({12'h000, 64'h0F0E0D0C0B0A0908});
    for (int i = 0; i < 16; i++) send(32'(i));
    wait_done("wrap");

    // Partial word on the N_PE=5 instance
    tick();
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    q5.push_back({12'h0AB, 64'h000000A5A4A3A2A1});
    for (int i = 0; i < 5; i++) begin
      in_valid5 = 1'b1;
      in_data5  = 32'(32'hA1 + i);
      @(negedge clk);
      check("p5_ready", {63'd0, in_ready5}, 64'd1);
      tick();
    end
    in_valid5 = 1'b0;
    begin
      int n = 0;
      while (n < 50 && !done5) begin
        @(negedge clk);
        n++;
      end
    end
    check("p5_done", {63'd0, done5}, 64'd1);
    check("p5_sb_empty", 64'(q5.size()), 64'd0);
    tick();

    // Reset mid-COLLECT with a word waiting in the buffer
    wr_gnt = 1'b0;
    start_drain(1'b0, 12'h050, 8'd1);
    for (int i = 0; i < 8; i++) send(32'(i));
    in_valid = 1'b1; in_data = 32'd8;
    dc = done_cnt;
    @(negedge clk);
    check("mr_req_before", {63'd0, wr_req}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mr_wr_req", {63'd0, wr_req}, 64'd0);
    check("mr_busy", {63'd0, busy}, 64'd0);
    check("mr_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mr_no_done", 64'(done_cnt - dc), 64'd0);
    tick();
    wr_gnt = 1'b1;
    start_drain(1'b0, 12'h010, 8'd1);
    push_case1(12'h010);
    for (int i = 0; i < 16; i++) send(32'(i));
    wait_done("mr_rerun");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
